// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: valid/ready in, one pipeline register out.
// Define RV_DECODE_MEXT_EN to decode the M extension (exe_fun 18-25).
module rv_decode_stage #(
   parameter int XLEN  = 32,
   parameter int EXE_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [EXE_W-1:0] out_exe_fun,
   output logic [1:0]       out_op1_sel,
   output logic             out_op2_sel,
   output logic [XLEN-1:0]  out_imm,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic             out_mem_wen,
   output logic             out_rf_wen,
   output logic [1:0]       out_wb_sel,
   output logic             out_illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam logic [4:0] FN_ADD  = 5'd0,  FN_SUB  = 5'd1,  FN_AND  = 5'd2,  FN_OR   = 5'd3;
   localparam logic [4:0] FN_XOR  = 5'd4,  FN_SLL  = 5'd5,  FN_SRL  = 5'd6,  FN_SRA  = 5'd7;
   localparam logic [4:0] FN_SLT  = 5'd8,  FN_SLTU = 5'd9,  FN_BEQ  = 5'd10, FN_BNE  = 5'd11;
   localparam logic [4:0] FN_BLT  = 5'd12, FN_BGE  = 5'd13, FN_BLTU = 5'd14, FN_BGEU = 5'd15;
   localparam logic [4:0] FN_JALR = 5'd16;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rd;
   assign opcode = in_inst[6:0];
   assign rd     = in_inst[11:7];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];

   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u = {in_inst[31:12], 12'b0};
   assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

   logic [4:0]  fun;
   logic [31:0] imm32;
   logic [1:0]  op1_d, wb_d;
   logic        op2_d, rf_wen_d, mem_wen_d, ill_d;

   always_comb begin
      // NOTE: every signal gets a default first so no decode path can infer a latch.
      fun       = FN_ADD;
      imm32     = '0;
      op1_d     = 2'd0;
      op2_d     = 1'b0;
      wb_d      = 2'd0;
      rf_wen_d  = 1'b0;
      mem_wen_d = 1'b0;
      ill_d     = 1'b0;
      case (opcode)
         OPC_OP: begin
            rf_wen_d = 1'b1;
            case (funct7)
               7'b0000000: begin
                  case (funct3)
                     3'b000:  fun = FN_ADD;
                     3'b001:  fun = FN_SLL;
                     3'b010:  fun = FN_SLT;
                     3'b011:  fun = FN_SLTU;
                     3'b100:  fun = FN_XOR;
                     3'b101:  fun = FN_SRL;
                     3'b110:  fun = FN_OR;
                     default: fun = FN_AND;
                  endcase
               end
               7'b0100000: begin
                  if (funct3 == 3'b000)      fun = FN_SUB;
                  else if (funct3 == 3'b101) fun = FN_SRA;
                  else                       ill_d = 1'b1;
               end
`ifdef RV_DECODE_MEXT_EN
               7'b0000001: fun = 5'd18 + {2'b00, funct3};
`else
               7'b0000001: ill_d = 1'b1;
`endif
               default: ill_d = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            op2_d    = 1'b1;
            rf_wen_d = 1'b1;
            imm32    = imm_i;
            case (funct3)
               3'b000:  fun = FN_ADD;
               3'b010:  fun = FN_SLT;
               3'b011:  fun = FN_SLTU;
               3'b100:  fun = FN_XOR;
               3'b110:  fun = FN_OR;
               3'b111:  fun = FN_AND;
               3'b001: begin
                  fun   = FN_SLL;
                  ill_d = (funct7 != 7'b0000000);
               end
               default: begin
                  if (funct7 == 7'b0000000)      fun = FN_SRL;
                  else if (funct7 == 7'b0100000) fun = FN_SRA;
                  else                           ill_d = 1'b1;
               end
            endcase
         end
         OPC_LOAD: begin
            op2_d    = 1'b1;
            wb_d     = 2'd1;
            rf_wen_d = 1'b1;
            imm32    = imm_i;
            ill_d    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            op2_d     = 1'b1;
            mem_wen_d = 1'b1;
            imm32     = imm_s;
            ill_d     = funct3[2] || (funct3 == 3'b011);
         end
         OPC_BRANCH: begin
            imm32 = imm_b;
            case (funct3)
               3'b000:  fun = FN_BEQ;
               3'b001:  fun = FN_BNE;
               3'b100:  fun = FN_BLT;
               3'b101:  fun = FN_BGE;
               3'b110:  fun = FN_BLTU;
               3'b111:  fun = FN_BGEU;
               default: ill_d = 1'b1;
            endcase
         end
         OPC_LUI:   begin op1_d = 2'd2; op2_d = 1'b1; rf_wen_d = 1'b1; imm32 = imm_u; end
         OPC_AUIPC: begin op1_d = 2'd1; op2_d = 1'b1; rf_wen_d = 1'b1; imm32 = imm_u; end
         OPC_JAL: begin
            op1_d = 2'd1; op2_d = 1'b1; wb_d = 2'd2; rf_wen_d = 1'b1; imm32 = imm_j;
         end
         OPC_JALR: begin
            fun = FN_JALR; op2_d = 1'b1; wb_d = 2'd2; rf_wen_d = 1'b1; imm32 = imm_i;
            ill_d = (funct3 != 3'b000);
         end
         OPC_FENCE: ill_d = (funct3 != 3'b000);
         default:   ill_d = 1'b1;
      endcase
      // Illegal encodings still travel downstream, but as a side-effect-free ADD.
      if (ill_d) begin
         fun       = FN_ADD;
         rf_wen_d  = 1'b0;
         mem_wen_d = 1'b0;
      end
      if (rd == 5'd0) rf_wen_d = 1'b0;
   end

   logic             valid_q, op2_q, mem_wen_q, rf_wen_q, ill_q;
   logic [XLEN-1:0]  pc_q, imm_q;
   logic [EXE_W-1:0] exe_q;
   logic [1:0]       op1_q, wb_q;
   logic [4:0]       rs1_q, rs2_q, rd_q;
   logic             accept;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q <= '0; exe_q <= '0; op1_q <= '0; op2_q <= 1'b0; imm_q <= '0;
         rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
         mem_wen_q <= 1'b0; rf_wen_q <= 1'b0; wb_q <= '0; ill_q <= 1'b0;
      end else begin
         if (flush)          valid_q <= 1'b0;
         else if (accept)    valid_q <= 1'b1;
         else if (out_ready) valid_q <= 1'b0;
         if (accept) begin
            pc_q      <= in_pc;
            exe_q     <= EXE_W'(fun);
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            imm_q     <= XLEN'($signed(imm32));
            rs1_q     <= in_inst[19:15];
            rs2_q     <= in_inst[24:20];
            rd_q      <= rd;
            mem_wen_q <= mem_wen_d;
            rf_wen_q  <= rf_wen_d;
            wb_q      <= wb_d;
            ill_q     <= ill_d;
         end
      end
   end

   assign out_valid   = valid_q;
   assign out_pc      = pc_q;
   assign out_exe_fun = exe_q;
   assign out_op1_sel = op1_q;
   assign out_op2_sel = op2_q;
   assign out_imm     = imm_q;
   assign out_rs1     = rs1_q;
   assign out_rs2     = rs2_q;
   assign out_rd      = rd_q;
   assign out_mem_wen = mem_wen_q;
   assign out_rf_wen  = rf_wen_q;
   assign out_wb_sel  = wb_q;
   assign out_illegal = ill_q;

endmodule
